// File: rtl/rd_fram_pkg.sv
// rd_fram_pkg: shared constants, prefetch state type and parameter checks for the frame-read FIFO.
package rd_fram_pkg;
   localparam int LANE_LSB_FIRST = 0;
   localparam int LANE_MSB_FIRST = 1;
   // bit 1: output register valid, bit 0: RAM read data holds the next lane to transfer
   typedef enum logic [1:0] {
      PF_EMPTY         = 2'b00,
      PF_FETCH         = 2'b01,
      PF_VALID         = 2'b10,
      PF_FETCH_OVERLAP = 2'b11
   } pf_state_e;
   function automatic int clog2(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
   function automatic bit cfg_ok(input int wr_w, input int rd_w, input int ratio, input int aw, input int burst);
      return ratio >= 1 && ratio <= 32 && (ratio & (ratio - 1)) == 0 && wr_w == rd_w * ratio &&
             burst >= 1 && burst <= (1 << aw);
   endfunction
endpackage

// File: rtl/fram_sdp_ram.sv
// fram_sdp_ram: inferred simple dual-port RAM with one write port and one registered read port.
module fram_sdp_ram #(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rdata_q;
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata_q <= mem[raddr];
   end
   assign rdata = rdata_q;
endmodule

// File: rtl/rd_fram_wconv_fifo.sv
// rd_fram_wconv_fifo: first-word-fall-through FIFO taking wide DDR read beats and emitting narrow pixel words.
// The RAM is addressed from the next fetch pointer so its output always tracks the entry being unpacked.
module rd_fram_wconv_fifo
   import rd_fram_pkg::*;
#(
   parameter int WR_DATA_WIDTH = 256,
   parameter int RD_DATA_WIDTH = 32,
   parameter int RATIO         = 8,
   parameter int WR_ADDR_WIDTH = 9,
   parameter int BURST_LEN     = 16,
   parameter int LANE_ORDER    = LANE_LSB_FIRST
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                flush,
   input  logic                                wr_valid,
   output logic                                wr_ready,
   input  logic [WR_DATA_WIDTH-1:0]            wr_data,
   output logic                                rd_valid,
   input  logic                                rd_ready,
   output logic [RD_DATA_WIDTH-1:0]            rd_data,
   output logic [WR_ADDR_WIDTH+clog2(RATIO):0] rd_level,
   output logic [WR_ADDR_WIDTH:0]              free_ent,
   output logic                                burst_req
);
   localparam int L     = clog2(RATIO);
   localparam int LW    = (L == 0) ? 1 : L;
   localparam int PW    = WR_ADDR_WIDTH + 1;
   localparam int NW    = PW + L;
   localparam int DEPTH = 1 << WR_ADDR_WIDTH;

   if (!cfg_ok(WR_DATA_WIDTH, RD_DATA_WIDTH, RATIO, WR_ADDR_WIDTH, BURST_LEN)) begin : g_bad_cfg
      $fatal(1, "rd_fram_wconv_fifo: illegal parameter set");
   end

   pf_state_e                st_q, st_d;
   logic [PW-1:0]            wr_ptr_q, wr_ptr_d, free_q, free_d;
   logic [NW-1:0]            rd_ptr_q, rd_ptr_d;
   logic [RD_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                     wr_ready_q, wr_ready_d, burst_req_q, burst_req_d;
   logic [WR_DATA_WIDTH-1:0] ram_rdata;
   logic [RD_DATA_WIDTH-1:0] lanes [RATIO];
   logic [LW-1:0]            lane, sel;
   logic                     out_vld, ram_vld, wr_acc, pop, load, rel;

   fram_sdp_ram #(.DATA_WIDTH(WR_DATA_WIDTH), .ADDR_WIDTH(WR_ADDR_WIDTH)) u_ram (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr_q[WR_ADDR_WIDTH-1:0]),
      .wdata (wr_data),
      .raddr (WR_ADDR_WIDTH'(rd_ptr_d >> L)),
      .rdata (ram_rdata)
   );

   always_comb begin
      out_vld     = st_q inside {PF_VALID, PF_FETCH_OVERLAP};
      ram_vld     = st_q inside {PF_FETCH, PF_FETCH_OVERLAP};
      for (int i = 0; i < RATIO; i++) lanes[i] = ram_rdata[i*RD_DATA_WIDTH +: RD_DATA_WIDTH];
      wr_acc      = wr_valid & wr_ready_q & ~flush;
      pop         = out_vld & rd_ready;
      load        = ram_vld & (~out_vld | pop);
      lane        = LW'(rd_ptr_q & NW'(RATIO - 1));
      sel         = (LANE_ORDER == LANE_MSB_FIRST) ? LW'(RATIO - 1) - lane : lane;
      rel         = load & (lane == LW'(RATIO - 1));
      wr_ptr_d    = flush ? '0 : wr_ptr_q + PW'(wr_acc);
      rd_ptr_d    = flush ? '0 : rd_ptr_q + NW'(load);
      free_d      = flush ? PW'(DEPTH) : free_q - PW'(wr_acc) + PW'(rel);
      wr_ready_d  = ~flush & (free_d != '0);
      burst_req_d = ~flush & (free_d >= PW'(BURST_LEN));
      // RAM data is usable next cycle only if the addressed entry was written before this edge
      st_d        = flush ? PF_EMPTY :
                    pf_state_e'({load | (out_vld & ~pop), PW'(rd_ptr_d >> L) != wr_ptr_q});
      rd_data_d   = (load & ~flush) ? lanes[sel] : rd_data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q        <= PF_EMPTY;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         free_q      <= PW'(DEPTH);
         rd_data_q   <= '0;
         wr_ready_q  <= 1'b0;
         burst_req_q <= 1'b0;
      end else begin
         st_q        <= st_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         free_q      <= free_d;
         rd_data_q   <= rd_data_d;
         wr_ready_q  <= wr_ready_d;
         burst_req_q <= burst_req_d;
      end
   end

   assign wr_ready  = wr_ready_q;
   assign burst_req = burst_req_q;
   assign rd_valid  = out_vld;
   assign rd_data   = rd_data_q;
   assign free_ent  = free_q;
   assign rd_level  = (NW'(wr_ptr_q) << L) - rd_ptr_q + NW'(out_vld);
endmodule
